r16_ntt_stage_ctrl: RTL

//  Sequences a multi-stage radix-16 NTT through the single R16_BU datapath.
//  Per stage it issues one 16-point butterfly group per cycle: data-memory

---
 rtl/r16_ntt_stage_ctrl_if.sv | 37 +++
 rtl/r16_ntt_stage_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/r16_ntt_stage_ctrl_if.sv
// Control/handshake bundle between the radix-16 NTT stage sequencer and its
// host, data memory, twiddle ROM and R16_BU datapath.
interface r16_ntt_stage_ctrl_if #(
    parameter int unsigned GROUPS    = 16,
    parameter int unsigned MAX_STAGE = 4
);
    localparam int unsigned GW  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned SW  = (MAX_STAGE > 1) ? $clog2(MAX_STAGE) : 1;
    localparam int unsigned NSW = $clog2(MAX_STAGE) + 1;
    localparam int unsigned TW  = (GROUPS * MAX_STAGE > 1) ? $clog2(GROUPS * MAX_STAGE) : 1;

    logic           start;
    logic [NSW-1:0] num_stage;
    logic           hold;
    logic           busy;
    logic           done;
    logic           rd_en;
    logic [GW-1:0]  rd_group;
    logic [SW-1:0]  rd_stage;
    logic [TW-1:0]  tw_idx;
    logic           bu_valid;
    logic           wr_en;
    logic [GW-1:0]  wr_group;
    logic [SW-1:0]  wr_stage;

    modport master (
        output start, num_stage, hold,
        input  busy, done, rd_en, rd_group, rd_stage, tw_idx, bu_valid, wr_en, wr_group,
               wr_stage
    );

    modport slave (
        input  start, num_stage, hold,
        output busy, done, rd_en, rd_group, rd_stage, tw_idx, bu_valid, wr_en, wr_group,
               wr_stage
    );
endinterface

// File: rtl/r16_ntt_stage_ctrl.sv
// Stage/group sequencer for a multi-stage radix-16 NTT on one R16_BU datapath,
// with a write-back delay line and a per-stage read-after-write barrier.
module r16_ntt_stage_ctrl #(
    parameter int unsigned GROUPS    = 16,
    parameter int unsigned MAX_STAGE = 4,
    parameter int unsigned BU_LAT    = 20,
    parameter int unsigned RD_LAT    = 1
) (
    input logic                  clk,
    input logic                  rst,
    r16_ntt_stage_ctrl_if.slave  bus
);
    localparam int unsigned GW  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned SW  = (MAX_STAGE > 1) ? $clog2(MAX_STAGE) : 1;
    localparam int unsigned NSW = $clog2(MAX_STAGE) + 1;
    localparam int unsigned TW  = (GROUPS * MAX_STAGE > 1) ? $clog2(GROUPS * MAX_STAGE) : 1;
    localparam int unsigned DLY = RD_LAT + BU_LAT;
    localparam int unsigned OW  = $clog2(DLY + 2);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    typedef struct packed {
        logic          v;
        logic [GW-1:0] g;
        logic [SW-1:0] s;
    } dl_t;

    state_e         state_q, state_d;
    logic [NSW-1:0] num_q, num_d;
    logic [SW-1:0]  stage_q, stage_d;
    logic [GW-1:0]  group_q, group_d;
    logic           rd_en_q, rd_en_d;
    logic [GW-1:0]  rd_group_q, rd_group_d;
    logic [SW-1:0]  rd_stage_q, rd_stage_d;
    logic [TW-1:0]  tw_idx_q, tw_idx_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [OW-1:0]  outst_q, outst_d;
    dl_t            dl_q [DLY];
    dl_t            dl_d [DLY];
    logic           wr_en;

    assign wr_en = dl_q[DLY-1].v;

    always_comb begin
        dl_d[0] = '{v: rd_en_q, g: rd_group_q, s: rd_stage_q};
        for (int i = 1; i < DLY; i++) dl_d[i] = dl_q[i-1];

        unique case ({rd_en_q, wr_en})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        state_d    = state_q;
        num_d      = num_q;
        stage_d    = stage_q;
        group_d    = group_q;
        rd_en_d    = 1'b0;
        rd_group_d = rd_group_q;
        rd_stage_d = rd_stage_q;
        tw_idx_d   = tw_idx_q;
        done_d     = 1'b0;
        busy_d     = (state_q == StIssue) || (state_q == StDrain);

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    num_d   = (bus.num_stage > NSW'(MAX_STAGE)) ? NSW'(MAX_STAGE) : bus.num_stage;
                    stage_d = '0;
                    group_d = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // An empty transform passes through DRAIN so done keeps its usual spacing.
                if (num_q == '0) begin
                    state_d = StDrain;
                end else if (!bus.hold) begin
                    rd_en_d    = 1'b1;
                    rd_group_d = group_q;
                    rd_stage_d = stage_q;
                    tw_idx_d   = TW'(int'(stage_q) * int'(GROUPS) + int'(group_q));
                    if (group_q == GW'(GROUPS - 1)) begin
                        group_d = '0;
                        state_d = StDrain;
                    end else begin
                        group_d = group_q + GW'(1);
                    end
                end
            end
            StDrain: begin
                // Leave on the cycle the stage's last write-back is presented.
                if (outst_d == '0) begin
                    if (int'(stage_q) + 1 >= int'(num_q)) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        stage_d = stage_q + SW'(1);
                        group_d = '0;
                        state_d = StIssue;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            num_q      <= '0;
            stage_q    <= '0;
            group_q    <= '0;
            rd_en_q    <= 1'b0;
            rd_group_q <= '0;
            rd_stage_q <= '0;
            tw_idx_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            outst_q    <= '0;
            for (int i = 0; i < DLY; i++) dl_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            stage_q    <= stage_d;
            group_q    <= group_d;
            rd_en_q    <= rd_en_d;
            rd_group_q <= rd_group_d;
            rd_stage_q <= rd_stage_d;
            tw_idx_q   <= tw_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            outst_q    <= outst_d;
            for (int i = 0; i < DLY; i++) dl_q[i] <= dl_d[i];
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.rd_group = rd_group_q;
    assign bus.rd_stage = rd_stage_q;
    assign bus.tw_idx   = tw_idx_q;
    assign bus.bu_valid = dl_q[RD_LAT-1].v;
    assign bus.wr_en    = wr_en;
    assign bus.wr_group = dl_q[DLY-1].g;
    assign bus.wr_stage = dl_q[DLY-1].s;
endmodule
